// File: rtl/ddr2_init_seq_if.sv
// ddr2_init_seq_if
// DFI control-channel bundle between the DDR2 init sequencer (master) and
// the DFI control mux / DDRPHY side (slave).
//   dfi_cke    clock enable
//   dfi_cs_n   chip selects (CS_WIDTH bits, driven identically)
//   dfi_ras_n  row strobe
//   dfi_cas_n  column strobe
//   dfi_we_n   write-enable strobe
//   dfi_ba     bank / mode-register select (BA_WIDTH bits)
//   dfi_addr   address / mode-register payload (ADDR_WIDTH bits)
//   dfi_odt    on-die termination control
interface ddr2_init_seq_if #(
    parameter int unsigned BA_WIDTH   = 3,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned CS_WIDTH   = 1
);
    logic                  dfi_cke;
    logic [CS_WIDTH-1:0]   dfi_cs_n;
    logic                  dfi_ras_n;
    logic                  dfi_cas_n;
    logic                  dfi_we_n;
    logic [BA_WIDTH-1:0]   dfi_ba;
    logic [ADDR_WIDTH-1:0] dfi_addr;
    logic                  dfi_odt;

    // The sequencer drives the command channel.
    modport master (
        output dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n,
               dfi_ba, dfi_addr, dfi_odt
    );

    // The mux / PHY side only observes it.
    modport slave (
        input dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n,
              dfi_ba, dfi_addr, dfi_odt
    );
endinterface

// File: rtl/ddr2_init_seq.sv
// ddr2_init_seq
// Power-up initialization sequencer for the DDR2 interface. After reset it
// walks the JEDEC DDR2 init sequence on the DFI control channel (CKE
// bring-up, PRE-all, EMRS2/3/1, MRS+DLL reset, PRE-all, 2x REF, MRS,
// OCD default/exit, DLL-lock wait) and then raises init_done.
// Ports:
//   clk        in   controller clock (same clock as DDRPHY)
//   rst_n      in   synchronous active-low reset
//   dfi        master modport of ddr2_init_seq_if (all outputs registered)
//   init_done  out  sequence complete; sticky until reset
module ddr2_init_seq #(
    parameter int unsigned BA_WIDTH   = 3,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned CS_WIDTH   = 1,
    parameter int unsigned T_PWRUP    = 40000,
    parameter int unsigned T_XPR      = 80,
    parameter int unsigned T_RP       = 3,
    parameter int unsigned T_MRD      = 2,
    parameter int unsigned T_RFC      = 26,
    parameter int unsigned T_DLLK     = 200,
    parameter logic [13:0] MR_VAL     = 14'h0652,
    parameter logic [13:0] EMR1_VAL   = 14'h0004,
    parameter logic [13:0] EMR2_VAL   = 14'h0000,
    parameter logic [13:0] EMR3_VAL   = 14'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    ddr2_init_seq_if.master   dfi,
    output logic              init_done
);

    // Every wait must fit the 16-bit counter and be at least one cycle;
    // ba=3 (EMRS3) and A10 (PRE-all) need enough bank/address bits.
    localparam bit CFG_OK = (ADDR_WIDTH >= 13) && (BA_WIDTH >= 2) && (CS_WIDTH >= 1) &&
                            (T_PWRUP >= 1) && (T_PWRUP <= 65535) &&
                            (T_XPR   >= 1) && (T_XPR   <= 65535) &&
                            (T_RP    >= 1) && (T_RP    <= 65535) &&
                            (T_MRD   >= 1) && (T_MRD   <= 65535) &&
                            (T_RFC   >= 1) && (T_RFC   <= 65535) &&
                            (T_DLLK  >= 1) && (T_DLLK  <= 65535);

    generate
        if (!CFG_OK) begin : g_cfg_error
            $error("ddr2_init_seq: timing parameter outside 1..65535 or bus too narrow");
        end
    endgenerate

    // Reset preloads the full power-up time because the reset edge itself is
    // not counted; every later command loads (T-1) on the edge it issues.
    localparam logic [15:0] PWRUP_CNT = 16'(T_PWRUP);
    localparam logic [15:0] XPR_M1    = 16'(T_XPR - 1);
    localparam logic [15:0] RP_M1     = 16'(T_RP - 1);
    localparam logic [15:0] MRD_M1    = 16'(T_MRD - 1);
    localparam logic [15:0] RFC_M1    = 16'(T_RFC - 1);
    localparam logic [15:0] DLLK_M1   = 16'(T_DLLK - 1);

    // EMRS1 base clears the OCD field (A9:7) and forces DLL enable (A0=0).
    localparam logic [13:0] EMR1_BASE = EMR1_VAL & ~14'h0381;

    localparam logic [ADDR_WIDTH-1:0] A_PRE      = ADDR_WIDTH'(14'h0400);
    localparam logic [ADDR_WIDTH-1:0] A_EMR2     = ADDR_WIDTH'(EMR2_VAL);
    localparam logic [ADDR_WIDTH-1:0] A_EMR3     = ADDR_WIDTH'(EMR3_VAL);
    localparam logic [ADDR_WIDTH-1:0] A_EMR1     = ADDR_WIDTH'(EMR1_BASE);
    localparam logic [ADDR_WIDTH-1:0] A_OCD_DEF  = ADDR_WIDTH'(EMR1_BASE | 14'h0380);
    localparam logic [ADDR_WIDTH-1:0] A_MR_DLLRST = ADDR_WIDTH'(MR_VAL | 14'h0100);
    localparam logic [ADDR_WIDTH-1:0] A_MR       = ADDR_WIDTH'(MR_VAL & ~14'h0100);

    localparam logic [BA_WIDTH-1:0] BA_MR   = BA_WIDTH'(0);
    localparam logic [BA_WIDTH-1:0] BA_EMR1 = BA_WIDTH'(1);
    localparam logic [BA_WIDTH-1:0] BA_EMR2 = BA_WIDTH'(2);
    localparam logic [BA_WIDTH-1:0] BA_EMR3 = BA_WIDTH'(3);

    // {ras_n, cas_n, we_n}; cs_n stays low for every cycle after CKE-high.
    localparam logic [2:0] STB_NOP = 3'b111;
    localparam logic [2:0] STB_PRE = 3'b010;
    localparam logic [2:0] STB_REF = 3'b001;
    localparam logic [2:0] STB_MRS = 3'b000;

    // Each state names the step most recently performed; the FSM moves on
    // when the wait loaded by that step has expired.
    typedef enum logic [3:0] {
        PWRUP, CKE_ON, PRE1, EMRS2, EMRS3, EMRS1, MRS_DLLRST, PRE2,
        REF1, REF2, MRS, OCD_DEF, OCD_EXIT, DLL_WAIT, DONE
    } state_t;

    state_t      state;
    logic [15:0] cnt;

    // Sequencer: every cycle defaults to a NOP with zero payload; when the
    // shared counter reaches zero the next command is issued for exactly one
    // cycle and its wait is loaded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= PWRUP;
            cnt           <= PWRUP_CNT;
            dfi.dfi_cke   <= 1'b0;
            dfi.dfi_cs_n  <= '1;
            {dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} <= STB_NOP;
            dfi.dfi_ba    <= '0;
            dfi.dfi_addr  <= '0;
            dfi.dfi_odt   <= 1'b0;
            init_done     <= 1'b0;
        end else begin
            {dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} <= STB_NOP;
            dfi.dfi_ba    <= '0;
            dfi.dfi_addr  <= '0;
            dfi.dfi_odt   <= 1'b0;
            if (cnt != 16'd0) begin
                cnt <= cnt - 16'd1;
            end

            if (cnt == 16'd0) begin
                case (state)
                    PWRUP: begin
                        state        <= CKE_ON;
                        cnt          <= XPR_M1;
                        dfi.dfi_cke  <= 1'b1;
                        dfi.dfi_cs_n <= '0;
                    end
                    CKE_ON: begin
                        state <= PRE1;
                        cnt   <= RP_M1;
                        {dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} <= STB_PRE;
                        dfi.dfi_addr <= A_PRE;
                    end
                    PRE1: begin
                        state <= EMRS2;
                        cnt   <= MRD_M1;
                        {dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} <= STB_MRS;
                        dfi.dfi_ba   <= BA_EMR2;
                        dfi.dfi_addr <= A_EMR2;
                    end
                    EMRS2: begin
                        state <= EMRS3;
                        cnt   <= MRD_M1;
                        {dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} <= STB_MRS;
                        dfi.dfi_ba   <= BA_EMR3;
                        dfi.dfi_addr <= A_EMR3;
                    end
                    EMRS3: begin
                        state <= EMRS1;
                        cnt   <= MRD_M1;
                        {dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} <= STB_MRS;
                        dfi.dfi_ba   <= BA_EMR1;
                        dfi.dfi_addr <= A_EMR1;
                    end
                    EMRS1: begin
                        state <= MRS_DLLRST;
                        cnt   <= MRD_M1;
                        {dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} <= STB_MRS;
                        dfi.dfi_ba   <= BA_MR;
                        dfi.dfi_addr <= A_MR_DLLRST;
                    end
                    MRS_DLLRST: begin
                        state <= PRE2;
                        cnt   <= RP_M1;
                        {dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} <= STB_PRE;
                        dfi.dfi_addr <= A_PRE;
                    end
                    PRE2: begin
                        state <= REF1;
                        cnt   <= RFC_M1;
                        {dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} <= STB_REF;
                    end
                    REF1: begin
                        state <= REF2;
                        cnt   <= RFC_M1;
                        {dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} <= STB_REF;
                    end
                    REF2: begin
                        state <= MRS;
                        cnt   <= MRD_M1;
                        {dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} <= STB_MRS;
                        dfi.dfi_ba   <= BA_MR;
                        dfi.dfi_addr <= A_MR;
                    end
                    MRS: begin
                        state <= OCD_DEF;
                        cnt   <= MRD_M1;
                        {dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} <= STB_MRS;
                        dfi.dfi_ba   <= BA_EMR1;
                        dfi.dfi_addr <= A_OCD_DEF;
                    end
                    OCD_DEF: begin
                        state <= OCD_EXIT;
                        cnt   <= DLLK_M1;
                        {dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} <= STB_MRS;
                        dfi.dfi_ba   <= BA_EMR1;
                        dfi.dfi_addr <= A_EMR1;
                    end
                    // OCD_EXIT only lasts past its issue cycle when T_DLLK > 1;
                    // with T_DLLK = 1 the counter is already zero here.
                    OCD_EXIT, DLL_WAIT: begin
                        state     <= DONE;
                        init_done <= 1'b1;
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= PWRUP;
                    end
                endcase
            end else if (state == OCD_EXIT) begin
                state <= DLL_WAIT;
            end
        end
    end

endmodule

// File: tb/tb_ddr2_init_seq.sv
// tb_ddr2_init_seq
// Directed scoreboard bench for ddr2_init_seq. A small-parameter instance is
// driven through reset hold, a sequence interrupted by reset after REF1, a
// full sequence and a 1000-cycle hold after init_done. A default-parameter
// instance runs alongside to check the absolute CKE and init_done edges.
`timescale 1ns/1ps
module tb_ddr2_init_seq;

    localparam int EV_CKE  = 0;
    localparam int EV_CMD  = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        string       name;
        int          kind;
        int          edge_n;
        logic [3:0]  cmd;
        logic [2:0]  ba;
        logic [13:0] addr;
    } exp_t;

    logic clk     = 1'b0;
    logic rst_n_s = 1'b0;
    logic rst_n_d = 1'b0;
    logic init_done_s;
    logic init_done_d;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    int   e_s = -1;
    int   e_d = -1;
    logic rst_seen_s  = 1'b1;
    logic rst_seen_d  = 1'b1;
    logic prev_cke_s  = 1'b0;
    logic done_seen_s = 1'b0;
    logic prev_cke_d  = 1'b0;
    logic done_seen_d = 1'b0;
    int   cmd_cnt_d   = 0;

    ddr2_init_seq_if #(.BA_WIDTH(3), .ADDR_WIDTH(14), .CS_WIDTH(1)) s_if ();
    ddr2_init_seq_if #(.BA_WIDTH(3), .ADDR_WIDTH(14), .CS_WIDTH(1)) d_if ();

    ddr2_init_seq #(
        .BA_WIDTH(3), .ADDR_WIDTH(14), .CS_WIDTH(1),
        .T_PWRUP(10), .T_XPR(5), .T_RP(3), .T_MRD(2), .T_RFC(8), .T_DLLK(20),
        .MR_VAL(14'h0652), .EMR1_VAL(14'h0004), .EMR2_VAL(14'h0000), .EMR3_VAL(14'h0000)
    ) u_small (
        .clk       (clk),
        .rst_n     (rst_n_s),
        .dfi       (s_if.master),
        .init_done (init_done_s)
    );

    ddr2_init_seq u_dflt (
        .clk       (clk),
        .rst_n     (rst_n_d),
        .dfi       (d_if.master),
        .init_done (init_done_d)
    );

    always #5 clk = ~clk;

    // Edge numbering: the first rising edge with rst_n high is E0.
    always @(posedge clk) begin
        rst_seen_s <= !rst_n_s;
        rst_seen_d <= !rst_n_d;
        e_s <= rst_n_s ? e_s + 1 : -1;
        e_d <= rst_n_d ? e_d + 1 : -1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushOne(input string name, input int kind, input int edge_n,
                           input logic [3:0] cmd, input logic [2:0] ba,
                           input logic [13:0] addr, input int max_edge);
        exp_t ex;
        ex.name   = name;
        ex.kind   = kind;
        ex.edge_n = edge_n;
        ex.cmd    = cmd;
        ex.ba     = ba;
        ex.addr   = addr;
        if (edge_n <= max_edge) sb_q.push_back(ex);
    endtask

    // Hand-computed schedule for T_PWRUP=10 T_XPR=5 T_RP=3 T_MRD=2 T_RFC=8 T_DLLK=20.
    task automatic pushRun(input int max_edge);
        pushOne("cke_on",     EV_CKE,  10, 4'b0111, 3'd0, 14'h0000, max_edge);
        pushOne("pre1",       EV_CMD,  15, 4'b0010, 3'd0, 14'h0400, max_edge);
        pushOne("emrs2",      EV_CMD,  18, 4'b0000, 3'd2, 14'h0000, max_edge);
        pushOne("emrs3",      EV_CMD,  20, 4'b0000, 3'd3, 14'h0000, max_edge);
        pushOne("emrs1",      EV_CMD,  22, 4'b0000, 3'd1, 14'h0004, max_edge);
        pushOne("mrs_dllrst", EV_CMD,  24, 4'b0000, 3'd0, 14'h0752, max_edge);
        pushOne("pre2",       EV_CMD,  26, 4'b0010, 3'd0, 14'h0400, max_edge);
        pushOne("ref1",       EV_CMD,  29, 4'b0001, 3'd0, 14'h0000, max_edge);
        pushOne("ref2",       EV_CMD,  37, 4'b0001, 3'd0, 14'h0000, max_edge);
        pushOne("mrs",        EV_CMD,  45, 4'b0000, 3'd0, 14'h0652, max_edge);
        pushOne("ocd_def",    EV_CMD,  47, 4'b0000, 3'd1, 14'h0384, max_edge);
        pushOne("ocd_exit",   EV_CMD,  49, 4'b0000, 3'd1, 14'h0004, max_edge);
        pushOne("init_done",  EV_DONE, 69, 4'b0111, 3'd0, 14'h0000, max_edge);
    endtask

    task automatic popCompare(input int kind, input logic [3:0] cmd);
        exp_t ex;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL stray_event edge=%0d kind=%0d cmd=%b required=no_event",
                     e_s, kind, cmd);
        end else begin
            ex = sb_q.pop_front();
            checkOutput({ex.name, "_edge"}, e_s, ex.edge_n);
            checkOutput({ex.name, "_payload"},
                        {9'd0, 2'(kind), cmd, s_if.dfi_ba, s_if.dfi_addr},
                        {9'd0, 2'(ex.kind), ex.cmd, ex.ba, ex.addr});
        end
    endtask

    task automatic applyStimulus(input logic rst_val, input int edges);
        rst_n_s = rst_val;
        repeat (edges) @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor for the small instance: reset values while in reset, events
    // (CKE rise, commands, init_done rise) popped against the scoreboard,
    // and per-cycle NOP / deselect / hold checks otherwise.
    always @(negedge clk) begin : mon_small
        logic [3:0] cmd;
        cmd = {s_if.dfi_cs_n[0], s_if.dfi_ras_n, s_if.dfi_cas_n, s_if.dfi_we_n};
        if (rst_seen_s) begin
            checkOutput("reset_values",
                        {8'd0, s_if.dfi_cke, cmd, s_if.dfi_ba, s_if.dfi_addr,
                         s_if.dfi_odt, init_done_s},
                        {8'd0, 1'b0, 4'b1111, 3'd0, 14'h0000, 1'b0, 1'b0});
            prev_cke_s  = 1'b0;
            done_seen_s = 1'b0;
        end else begin
            checkOutput("odt_low", {31'd0, s_if.dfi_odt}, 32'd0);
            if (s_if.dfi_cke && !prev_cke_s) popCompare(EV_CKE, cmd);
            if (init_done_s && !done_seen_s) popCompare(EV_DONE, cmd);
            if (s_if.dfi_cke && cmd != 4'b0111) begin
                popCompare(EV_CMD, cmd);
            end else if (s_if.dfi_cke) begin
                checkOutput("nop_payload", {15'd0, s_if.dfi_ba, s_if.dfi_addr}, 32'd0);
            end else begin
                checkOutput("pwrup_deselect", {27'd0, cmd, init_done_s}, {27'd0, 4'b1111, 1'b0});
            end
            if (done_seen_s) begin
                checkOutput("done_hold", {26'd0, s_if.dfi_cke, init_done_s, cmd},
                            {26'd0, 1'b1, 1'b1, 4'b0111});
            end
            prev_cke_s = s_if.dfi_cke;
            if (init_done_s) done_seen_s = 1'b1;
        end
    end

    // Monitor for the default instance: absolute CKE and init_done edges and
    // the number of non-NOP commands.
    always @(negedge clk) begin : mon_dflt
        logic [3:0] cmd;
        cmd = {d_if.dfi_cs_n[0], d_if.dfi_ras_n, d_if.dfi_cas_n, d_if.dfi_we_n};
        if (!rst_seen_d) begin
            if (d_if.dfi_cke && !prev_cke_d) checkOutput("dflt_cke_edge", e_d, 40000);
            if (d_if.dfi_cke && cmd != 4'b0111) cmd_cnt_d++;
            if (init_done_d && !done_seen_d) begin
                checkOutput("dflt_done_edge", e_d, 40350);
                done_seen_d = 1'b1;
            end
            prev_cke_d = d_if.dfi_cke;
        end
    end

    initial begin
        $display("[TB] ddr2_init_seq directed scoreboard run");
        rst_n_d = 1'b0;
        applyStimulus(1'b0, 5);

        // First sequence, cut by reset right after REF1 (E29).
        pushRun(29);
        rst_n_d = 1'b1;
        rst_n_s = 1'b1;
        for (int i = 0; i < 100 && e_s != 29; i++) @(negedge clk);
        checkOutput("reach_e29", e_s, 29);
        applyStimulus(1'b0, 1);
        checkOutput("partial_run_drained", sb_q.size(), 0);

        // Full sequence from the new E0, then a long hold after init_done.
        pushRun(1000);
        rst_n_s = 1'b1;
        for (int i = 0; i < 200 && !done_seen_s; i++) @(negedge clk);
        checkOutput("small_done_reached", {31'd0, done_seen_s}, 32'd1);
        repeat (1000) @(negedge clk);
        checkOutput("sb_drained", sb_q.size(), 0);

        for (int i = 0; i < 45000 && !done_seen_d; i++) @(negedge clk);
        checkOutput("dflt_done_reached", {31'd0, done_seen_d}, 32'd1);
        checkOutput("dflt_cmd_count", cmd_cnt_d, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
